// File: rtl/control_unit.sv
// Purpose: main instruction decode, ALU control decode and a doubleword data memory.
// Latency: decode and memory read are combinational (zero cycles); memory writes land on the next core edge.
// Backpressure: none; every opcode is accepted every cycle and the memory never stalls.
module control_unit #(
    parameter int MEM_WORDS = 32,
    parameter int DATA_W    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        opcode,
    input  logic [10:0]       funct,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              reg_to_loc,
    output logic              branch,
    output logic              mem_read,
    output logic              mem_to_reg,
    output logic              mem_write,
    output logic              alu_src,
    output logic              reg_write,
    output logic [1:0]        alu_op,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] mem_rdata
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ORR = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic [AW-1:0]     word_idx;
    logic              unused_addr_bits;

    // Byte offset and bits above the memory depth are dropped: misaligned
    // accesses hit the containing doubleword and addresses wrap.
    assign word_idx = mem_addr[AW+2:3];
    assign unused_addr_bits = ^mem_addr;

    // Main decode: unknown opcodes leave every strobe low so nothing changes state.
    always_comb begin
        reg_to_loc = 1'b0;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        alu_op     = 2'b00;
        case (opcode)
            OP_RTYPE: begin
                reg_write = 1'b1;
                alu_op    = 2'b10;
            end
            OP_LOAD: begin
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                mem_read   = 1'b1;
            end
            OP_ADDI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            OP_STORE: begin
                reg_to_loc = 1'b1;
                alu_src    = 1'b1;
                mem_write  = 1'b1;
            end
            OP_BRANCH: begin
                reg_to_loc = 1'b1;
                branch     = 1'b1;
                alu_op     = 2'b01;
            end
            default: ;
        endcase
    end

    // ALU control: address/branch classes are fixed, register ops decode funct.
    always_comb begin
        alu_ctrl = ALU_BAD;
        case (alu_op)
            2'b00: alu_ctrl = ALU_ADD;
            2'b01: alu_ctrl = ALU_SUB;
            default: begin
                case (funct)
                    11'b10001011000: alu_ctrl = ALU_ADD;
                    11'b11001011000: alu_ctrl = ALU_SUB;
                    11'b10001010000: alu_ctrl = ALU_AND;
                    11'b10101010000: alu_ctrl = ALU_ORR;
                    default:         alu_ctrl = ALU_BAD;
                endcase
            end
        endcase
    end

    // Data memory: reset wipes every word immediately; otherwise single-cycle store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_write) begin
            mem[word_idx] <= mem_wdata;
        end
    end

    // Unbypassed read: same-word store shows the old value until the edge.
    assign mem_rdata = mem_read ? mem[word_idx] : '0;

endmodule

// File: tb/tb_control_unit.sv
// Purpose: directed check of decode, ALU control and data memory of control_unit.
// Latency: inputs change on the falling edge, outputs sampled 1 time unit later.
// Backpressure: not applicable; the bench drives one vector per half-cycle.
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [10:0] funct;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        reg_to_loc, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [1:0]  alu_op;
    logic [3:0]  alu_ctrl;
    logic [63:0] mem_rdata;

    int n_vec;
    int n_err;

    control_unit #(.MEM_WORDS(32), .DATA_W(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .reg_to_loc (reg_to_loc),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_to_reg (mem_to_reg),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .alu_op     (alu_op),
        .alu_ctrl   (alu_ctrl),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Strobes packed {reg_to_loc,branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write,alu_op}.
    function automatic logic [8:0] strobes();
        return {reg_to_loc, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op};
    endfunction

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_AI = 7'b0010011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    logic [6:0]  dec_op  [6];
    logic [8:0]  dec_exp [6];
    logic [10:0] fn_in   [5];
    logic [3:0]  fn_exp  [5];

    // Store then leave the write opcode only for exactly one rising edge.
    task automatic store(input logic [63:0] addr, input logic [63:0] data);
        @(negedge clk);
        opcode    = OP_ST;
        mem_addr  = addr;
        mem_wdata = data;
        @(negedge clk);
        opcode    = OP_AI;
    endtask

    task automatic load_chk(input string tag, input logic [63:0] addr, input logic [63:0] exp);
        opcode   = OP_LD;
        mem_addr = addr;
        #1;
        chk(tag, mem_rdata, exp);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        opcode = OP_AI;
        funct = '0;
        mem_addr = '0;
        mem_wdata = '0;

        dec_op[0] = OP_R;     dec_exp[0] = 9'b000000110;
        dec_op[1] = OP_LD;    dec_exp[1] = 9'b001101100;
        dec_op[2] = OP_AI;    dec_exp[2] = 9'b000001100;
        dec_op[3] = OP_ST;    dec_exp[3] = 9'b100011000;
        dec_op[4] = OP_BR;    dec_exp[4] = 9'b110000001;
        dec_op[5] = 7'h7F;    dec_exp[5] = 9'b000000000;

        fn_in[0] = 11'b10001011000; fn_exp[0] = 4'b0010;
        fn_in[1] = 11'b11001011000; fn_exp[1] = 4'b0110;
        fn_in[2] = 11'b10001010000; fn_exp[2] = 4'b0000;
        fn_in[3] = 11'b10101010000; fn_exp[3] = 4'b0001;
        fn_in[4] = 11'b00000000000; fn_exp[4] = 4'b1111;

        // Reset state: memory cleared, load reads 0; decode works during reset.
        #3;
        load_chk("rst_read", 64'h10, 64'h0);
        opcode = OP_R;
        #1;
        chk("rst_decode", {55'd0, strobes()}, {55'd0, 9'b000000110});

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            opcode = dec_op[i];
            #1;
            chk($sformatf("decode_%h", dec_op[i]), {55'd0, strobes()}, {55'd0, dec_exp[i]});
        end

        opcode = OP_R;
        for (int i = 0; i < 5; i++) begin
            funct = fn_in[i];
            #1;
            chk($sformatf("aluctl_%b", fn_in[i]), {60'd0, alu_ctrl}, {60'd0, fn_exp[i]});
        end
        opcode = OP_BR;
        funct = 11'b10001010000;
        #1;
        chk("aluctl_branch", {60'd0, alu_ctrl}, {60'd0, 4'b0110});
        opcode = OP_LD;
        funct = 11'b11111111111;
        #1;
        chk("aluctl_load", {60'd0, alu_ctrl}, {60'd0, 4'b0010});
        opcode = OP_AI;

        // Aligned store, misaligned read of same word, read strobe gating.
        store(64'h10, 64'hDEADBEEF_01234567);
        load_chk("rd_0x10", 64'h10, 64'hDEADBEEF_01234567);
        load_chk("rd_0x17", 64'h17, 64'hDEADBEEF_01234567);
        opcode = OP_AI;
        #1;
        chk("rd_noread", mem_rdata, 64'h0);

        // Address wrap: 0x108 aliases 0x08 with 32 doublewords.
        store(64'h08, 64'hAA);
        load_chk("rd_0x08_first", 64'h08, 64'hAA);
        store(64'h108, 64'hBB);
        load_chk("rd_wrap", 64'h08, 64'hBB);
        load_chk("rd_0x10_kept", 64'h10, 64'hDEADBEEF_01234567);

        // Old value before the edge, new value after; no bypass.
        @(negedge clk);
        load_chk("rd_0x20_old", 64'h20, 64'h0);
        opcode = OP_ST;
        mem_wdata = 64'h55;
        @(posedge clk);
        #1;
        opcode = OP_LD;
        #1;
        chk("rd_0x20_new", mem_rdata, 64'h55);
        opcode = OP_AI;

        // Mid-cycle reset wipes memory at once; writes during reset are dropped.
        @(negedge clk);
        load_chk("rd_pre_rst", 64'h10, 64'hDEADBEEF_01234567);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_clear", mem_rdata, 64'h0);
        opcode = OP_ST;
        mem_addr = 64'h10;
        mem_wdata = 64'h1234;
        @(posedge clk);
        @(negedge clk);
        opcode = OP_LD;
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_write_blocked", mem_rdata, 64'h0);
        load_chk("rst_0x08_cleared", 64'h08, 64'h0);
        load_chk("rst_0x20_cleared", 64'h20, 64'h0);

        // Normal writes resume after reset release.
        store(64'h18, 64'h77);
        load_chk("rd_after_rst", 64'h18, 64'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
